// File: rtl/midi_event_tx.sv
// midi_event_tx: serialises one MIDI event (status + 0..2 data bytes) onto a UART line.
// Define MIDI_RUNNING_STATUS_EN to omit repeated channel status bytes.
module midi_event_tx #(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_event_valid,
  input  logic [7:0] midi_command,
  input  logic [6:0] midi_parameter_1,
  input  logic [6:0] midi_parameter_2,
  output logic       midi_event_ack,
  output logic       serial_tx,
  output logic       busy
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] TC = W'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [W-1:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] sel, last, first, nlast;
  logic [7:0] cmd, cur;
  logic [6:0] p1, p2;
  logic accept, tick, chan, skip;
  assign accept = midi_event_valid && state == IDLE && !midi_event_ack;
  assign tick = cnt == TC;
  assign chan = midi_command < 8'hF0;
  assign nlast = !chan ? 2'd0 : midi_command[7:5] == 3'b110 ? 2'd1 : 2'd2;
  assign first = skip ? 2'd1 : 2'd0;
  assign cur = sel == 2'd0 ? cmd : {1'b0, sel == 2'd1 ? p1 : p2};
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] run_status;
  assign skip = chan && midi_command == run_status;
  // channel status is remembered, F0-F7 forget it, real-time F8-FF is transparent
  always_ff @(posedge clk or posedge rst)
    if (rst) run_status <= '0;
    else if (accept && midi_command[7])
      run_status <= chan ? midi_command : midi_command[3] ? run_status : 8'h00;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = accept && midi_command[7] ? START : IDLE;
      START: state_d = tick ? DATA : START;
      DATA:  state_d = tick && bit_idx == 3'd7 ? STOP : DATA;
      STOP:  state_d = !tick ? STOP : sel == last ? IDLE : START;
    endcase
    serial_tx = state == START ? 1'b0 : state == DATA ? cur[bit_idx] : 1'b1;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      midi_event_ack <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      sel <= '0;
      last <= '0;
      cmd <= '0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      midi_event_ack <= accept;
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      if (accept) begin
        cmd <= midi_command;
        p1 <= midi_parameter_1;
        p2 <= midi_parameter_2;
        sel <= first;
        last <= nlast;
      end
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == STOP && tick) sel <= sel + 2'd1;
    end
endmodule

// File: tb/tb_midi_event_tx.sv
// tb_midi_event_tx: table, directed and random checks of midi_event_tx against a byte-level model.
module tb_midi_event_tx;
  localparam int CPB = 8;
`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [7:0] cmd = '0;
  logic [6:0] p1 = '0, p2 = '0;
  logic ack, serial_tx, busy;
  int total = 0, bad = 0;
  logic [7:0] m_rs = '0;
  logic [7:0] exp_q[$];

  midi_event_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .midi_event_valid(valid), .midi_command(cmd),
    .midi_parameter_1(p1), .midi_parameter_2(p2),
    .midi_event_ack(ack), .serial_tx(serial_tx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic [6:0] a, b;
    int n, nrs;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // message bytes the line should carry, from the byte-count and running-status rules
  function automatic void model(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    exp_q.delete();
    if (!c[7]) return;
    if (!(RS && c < 8'hF0 && c == m_rs)) exp_q.push_back(c);
    if (c < 8'hC0 || (c >= 8'hE0 && c < 8'hF0)) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b0, b});
    end else if (c < 8'hE0) exp_q.push_back({1'b0, a});
    if (RS) m_rs = c < 8'hF0 ? c : c < 8'hF8 ? 8'h00 : m_rs;
  endfunction

  task automatic run_event(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b,
                           input bit hold, input int exp_n, input string tag);
    logic tx_s[$];
    logic [9:0] fr;
    int len, acks, idle_bad, n, idx;
    bit got;
    model(c, a, b);
    n = exp_n >= 0 ? exp_n : exp_q.size();
    @(negedge clk);
    valid = 1'b1; cmd = c; p1 = a; p2 = b;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = ack;
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    if (!got) begin
      valid = 1'b0;
      return;
    end
    if (hold) begin
      cmd = 8'($urandom); p1 = 7'($urandom); p2 = 7'($urandom);
    end else valid = 1'b0;
    len = 0; acks = 0; idle_bad = 0;
    while (busy && len < 40 * CPB) begin
      tx_s.push_back(serial_tx);
      len++;
      @(negedge clk);
      if (ack) acks++;
      if (len == 20) valid = 1'b0;
    end
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (serial_tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    chk({tag, "_busy_len"}, 32'(len), 32'(n * 10 * CPB));
    chk({tag, "_extra_acks"}, 32'(acks), 32'd0);
    chk({tag, "_idle"}, 32'(idle_bad), 32'd0);
    foreach (exp_q[k]) begin
      for (int j = 0; j < 10; j++) begin
        idx = (k * 10 + j) * CPB + CPB / 2;
        fr[j] = idx < tx_s.size() ? tx_s[idx] : 1'bx;
      end
      chk($sformatf("%s_byte%0d", tag, k), 32'(fr), 32'({1'b1, exp_q[k], 1'b0}));
    end
  endtask

  initial begin
    logic [7:0] pool[8];
    logic [7:0] c;
    int idle_bad;
    bit got;
    pool = '{8'h90, 8'h90, 8'hC1, 8'hE0, 8'hF8, 8'hF6, 8'h45, 8'hB3};
    tbl[0]  = '{8'h90, 7'h3C, 7'h64, 3, 3};
    tbl[1]  = '{8'h90, 7'h3E, 7'h40, 3, 2};
    tbl[2]  = '{8'hC1, 7'h05, 7'h7F, 2, 2};
    tbl[3]  = '{8'hF8, 7'h00, 7'h00, 1, 1};
    tbl[4]  = '{8'hC1, 7'h06, 7'h00, 2, 1};
    tbl[5]  = '{8'hF6, 7'h00, 7'h00, 1, 1};
    tbl[6]  = '{8'hC1, 7'h07, 7'h00, 2, 2};
    tbl[7]  = '{8'h45, 7'h11, 7'h22, 0, 0};
    tbl[8]  = '{8'hE0, 7'h01, 7'h02, 3, 3};
    tbl[9]  = '{8'hFF, 7'h00, 7'h00, 1, 1};
    tbl[10] = '{8'hB0, 7'h7F, 7'h7F, 3, 3};
    tbl[11] = '{8'h90, 7'h3C, 7'h64, 3, 3};
    tbl[12] = '{8'hF8, 7'h00, 7'h00, 1, 1};
    tbl[13] = '{8'h90, 7'h3C, 7'h00, 3, 2};
    tbl[14] = '{8'h90, 7'h3C, 7'h64, 3, 2};
    tbl[15] = '{8'hF6, 7'h00, 7'h00, 1, 1};
    tbl[16] = '{8'h90, 7'h3C, 7'h00, 3, 3};
    #2;
    chk("rst_tx", 32'(serial_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i])
      run_event(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].c[7] && i % 2 == 0,
                RS ? tbl[i].nrs : tbl[i].n, $sformatf("vec%0d", i));

    // reset during bit 4 of the second byte aborts the message and clears running status
    @(negedge clk);
    valid = 1'b1; cmd = 8'h90; p1 = 7'h3C; p2 = 7'h64;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = ack;
    end
    chk("midrst_ack", 32'(got), 32'd1);
    valid = 1'b0;
    m_rs = '0;
    repeat ((10 + 1 + 4) * CPB + CPB / 2) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(serial_tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 12 * CPB; i++) begin
      @(negedge clk);
      if (serial_tx !== 1'b1 || busy !== 1'b0 || ack !== 1'b0) idle_bad++;
    end
    chk("midrst_no_resume", 32'(idle_bad), 32'd0);
    run_event(8'h90, 7'h3C, 7'h64, 1'b0, 3, "post_rst");

    for (int i = 0; i < 25; i++) begin
      c = $urandom_range(0, 3) == 0 ? 8'($urandom) : pool[$urandom_range(0, 7)];
      run_event(c, 7'($urandom), 7'($urandom), c[7] && $urandom_range(0, 1) == 1, -1,
                $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/midi_event_tx.md
MIDI_EVENT_TX -- requirements
Module: midi_event_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 512, clk cycles per serial bit (16 MHz / 31250 baud).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 midi_event_valid  input  1  an event is presented; held by the producer until acked.
REQ-005 midi_command  input  8  MIDI status byte.
REQ-006 midi_parameter_1  input  7  first data byte.
REQ-007 midi_parameter_2  input  7  second data byte.
REQ-008 midi_event_ack  output  1  one-cycle pulse; the event was consumed.
REQ-009 serial_tx  output  1  UART line to the MIDI out driver; idle high.
REQ-010 busy  output  1  high while any byte of a message is on the line.

Function
REQ-011 The block SHALL accept an event only at a clk edge where midi_event_valid=1, the state is IDLE and midi_event_ack=0.
REQ-012 On accept, the block SHALL latch all three input fields and drive midi_event_ack=1 for exactly the following cycle.
REQ-013 On accept, the first byte's start bit SHALL begin at that same edge, and busy SHALL go high at that edge.
REQ-014 Byte count by command: 0x80-0xBF and 0xE0-0xEF send 3 bytes (status, p1, p2). 0xC0-0xDF send 2 bytes (status, p1). 0xF0-0xFF send 1 byte (status only).
REQ-015 If midi_command[7]=0, the event SHALL be acked with no line activity; busy stays 0.
REQ-016 Each data byte SHALL be sent as {1'b0, parameter}.
REQ-017 Frame format: start bit 0, 8 data bits LSB first, one stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles; one byte takes 10*CLKS_PER_BIT cycles.
REQ-018 Bytes of one message SHALL be sent back-to-back, with the next start bit immediately after the previous stop bit.
REQ-019 Sequencing SHALL use a state machine IDLE -> START -> DATA (bit counter 0..7) -> STOP.
REQ-020 From STOP, the machine SHALL go to START if bytes remain in the message, else to IDLE.
REQ-021 busy SHALL fall on the edge that ends the last stop bit; a new event can be accepted at the earliest on the next edge.
REQ-022 Input changes while not IDLE SHALL be ignored; the latched values are used for the whole message.
REQ-023 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reload at terminal count; it SHALL not free-run while IDLE.

Reset
REQ-024 While rst=1, asynchronously: serial_tx=1, midi_event_ack=0, busy=0, state=IDLE, counters=0, running-status register cleared.
REQ-025 Reset mid-frame SHALL abort the byte; serial_tx goes high immediately and no partial message resumes after release.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN controls running status.
REQ-027 With the macro defined: if a channel command (0x80-0xEF) equals the last status byte sent, the status byte SHALL be omitted and only the data bytes sent.
REQ-028 With the macro defined: the running-status register updates on every sent channel status. Commands 0xF0-0xF7 clear it. 0xF8-0xFF leave it unchanged.
REQ-029 Without the macro: the status byte SHALL always be sent and no running-status register exists.

Verification
REQ-030 Send 0x90,0x3C,0x64 -> ack pulse of 1 cycle; line carries 0x90,0x3C,0x64; busy high for exactly 15360 cycles.
REQ-031 Send 0xC1,0x05,0x7F -> 2 bytes 0xC1,0x05 only; busy high for 10240 cycles.
REQ-032 Send 0x90,0x3C,0x64 then 0x90,0x3E,0x40 -> with macro the second message is 0x3E,0x40 only (10240 cycles); without macro it is 0x90,0x3E,0x40.
REQ-033 With macro, send 0x90,0x3C,0x64; 0xF8; 0x90,0x3C,0x00 -> 0xF8 alone, then 0x3C,0x00. Replace 0xF8 with 0xF6 -> third message includes 0x90.
REQ-034 Assert rst during bit 4 of byte 2 -> serial_tx=1 and busy=0 in the same cycle; the next 0x90 event sends its status byte.
REQ-035 Send command 0x45 -> single ack pulse, serial_tx stays 1, busy stays 0; with valid held during a message, exactly one ack per event.
